serial_add_ctrl: RTL and testbench

Bit-serial adder controller that shares a single instance of the team's one-bit `fulladder` cell across a WIDTH-bit addition. It loads two operands and a carry-in on a start request, feeds the full adder one bit per clock from LSB to MSB, and collects the sum and carry. It then presents a registered result with a one-cycle done pulse. It sits between register-file or bus logic and the shared full-adder datapath, trading latency for area.

---
 rtl/serial_add_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder built around one shared fulladder cell, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;

    fulladder u_fa (a_sr[0], b_sr[0], carry, fa_s, fa_c);

    // Subtract is a + ~b + 1, so only the B load value and carry seed change.
    always_comb begin
        b_ld = b;
        c_ld = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_ld = ~b;
            c_ld = 1'b1;
        end
`endif
    end

    // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
    always_comb begin
        s_nxt            = s_sr >> 1;
        s_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_ld;
                        carry <= c_ld;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_nxt;
                    carry <= fa_c;
                    if (cnt == LAST) begin
                        sum   <= s_nxt;
                        cout  <= fa_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random bench for serial_add_ctrl against an arithmetic reference model.
// Subtract tests are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic ts, output logic [W-1:0] s, output logic c);
        logic [W:0] r;
        if (ts) begin
            s = ta - tb_;
            c = (ta >= tb_);
        end else begin
            r = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
            s = r[W-1:0];
            c = r[W];
        end
    endtask

    // Launches at the current negedge; returns at the first negedge where a new start is legal.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input int glitch_idx);
        logic [W-1:0] ns;
        logic         nc;
        int           done_idx;
        int           n_done;
        int           n_busy;
        done_idx = -1;
        n_done   = 0;
        n_busy   = 0;
        model(ta, tb_, tc, ts, ns, nc);
        a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = ts;
`endif
        @(negedge clk);
        for (int i = 0; i <= W + 1; i++) begin
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_idx < 0) done_idx = i;
            end
            if (i == W - 1) begin
                check("sum_hold", 64'(sum), 64'(exp_sum));
                check("cout_hold", 64'(cout), 64'(exp_cout));
            end
            if (i == W) begin
                exp_sum  = ns;
                exp_cout = nc;
                check("sum", 64'(sum), 64'(exp_sum));
                check("cout", 64'(cout), 64'(exp_cout));
            end
            if (i == glitch_idx) begin
                start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
            end else begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom);
            end
            if (i < W + 1) @(negedge clk);
        end
        start = 1'b0;
        check("done_cycle", 64'(done_idx), 64'(W));
        check("done_count", 64'(n_done), 64'(1));
        check("busy_cycles", 64'(n_busy), 64'(W + 1));
        check("sum_after", 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        int n_done;
        logic         rc;
        logic         rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1; start = 1'b1; a = 8'h3C; b = 8'h5A; cin = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        exp_sum = '0; exp_cout = 1'b0;

        // Reset held with start asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_sum", 64'(sum), 64'(0));
            check("rst_cout", 64'(cout), 64'(0));
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(0));

        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, -1);
        check("3c5a_sum", 64'(sum), 64'(8'h96));

        // Back-to-back at the first legal cycle
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        check("ff01_sum", 64'(sum), 64'(8'h00));
        check("ff01_cout", 64'(cout), 64'(1));
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1);
        check("ffff_sum", 64'(sum), 64'(8'hFF));
        check("ffff_cout", 64'(cout), 64'(1));

        // Start pulse sampled at edge 3 is ignored
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 2);
        check("glitch_sum", 64'(sum), 64'(8'h96));
        n_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("glitch_no_second", 64'(n_done), 64'(0));

        // Reset mid-run
        a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_sum", 64'(sum), 64'(0));
        check("midrst_cout", 64'(cout), 64'(0));
        exp_sum = '0; exp_cout = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'(0));
        run_op(8'h01, 8'h02, 1'b1, 1'b0, -1);
        check("010201_sum", 64'(sum), 64'(8'h04));
        check("010201_cout", 64'(cout), 64'(0));

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h03, 1'b0, 1'b1, -1);
        check("sub53_sum", 64'(sum), 64'(8'h02));
        check("sub53_cout", 64'(cout), 64'(1));
        run_op(8'h03, 8'h05, 1'b1, 1'b1, -1);
        check("sub35_sum", 64'(sum), 64'(8'hFE));
        check("sub35_cout", 64'(cout), 64'(0));
`endif

        // Random back-to-back operations
        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
